// File: rtl/knn_vote_if.sv
// Sorter-to-voter bundle: sorted class labels in, majority-class result out.
interface knn_vote_if #(
    parameter int N = 64,
    parameter int B = 32
);
    // valid_sort is a one-cycle strobe with no backpressure; a strobe that
    // arrives while the voter is busy is dropped, so masters watch busy.
    logic         valid_sort;
    logic [B-1:0] type_array_sorted [0:N-1];
    logic [B-1:0] class_out;
    logic [7:0]   class_votes;
    logic         no_vote;
    logic         valid_class;
    logic         busy;

    modport master (
        output valid_sort, type_array_sorted,
        input  class_out, class_votes, no_vote, valid_class, busy
    );

    modport slave (
        input  valid_sort, type_array_sorted,
        output class_out, class_votes, no_vote, valid_class, busy
    );
endinterface

// File: rtl/knn_vote.sv
// K-nearest-neighbour majority vote over the first K sorted labels.
// Optional KNN_TIE_NEAREST_EN: ties go to the class with the nearest member.
module knn_vote #(
    parameter int N = 64,
    parameter int B = 32,
    parameter int K = 5,
    parameter int C = 8
) (
    input  logic       clk,
    input  logic       rst,
    knn_vote_if.slave  bus,
    output logic [1:0] state_o
);
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [B-1:0]   type_q  [K];
    logic [7:0]     vote_q  [C];
    logic [IW-1:0]  idx_q;
    logic [CW-1:0]  c_q;
    logic [CW-1:0]  best_cls_q;
    logic [7:0]     best_cnt_q;
    logic [CW-1:0]  class_out_q;
    logic [7:0]     class_votes_q;
    logic           no_vote_q;
`ifdef KNN_TIE_NEAREST_EN
    logic [IW-1:0]  first_q [C];
`endif

    logic           last_idx, last_c;
    logic [B-1:0]   cur_type;
    logic           in_range;
    logic [CW-1:0]  cur_cls;
    logic [7:0]     scan_cnt;
    logic           take;
    logic [CW-1:0]  new_cls;
    logic [7:0]     new_cnt;

    assign last_idx = (idx_q == IW'(K - 1));
    assign last_c   = (c_q == CW'(C - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.valid_sort) state_d = S_COUNT;
            S_COUNT: if (last_idx)       state_d = S_SCAN;
            S_SCAN:  if (last_c)         state_d = S_DONE;
            S_DONE:                      state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cur_type = type_q[idx_q];
        in_range = (cur_type < B'(C));
        cur_cls  = cur_type[CW-1:0];
        scan_cnt = vote_q[c_q];
        take     = (scan_cnt > best_cnt_q);
`ifdef KNN_TIE_NEAREST_EN
        // A zero count never has a meaningful first index, so it cannot win a tie.
        if ((scan_cnt == best_cnt_q) && (scan_cnt != 8'd0) &&
            (first_q[c_q] < first_q[best_cls_q]))
            take = 1'b1;
`endif
        new_cls = take ? c_q      : best_cls_q;
        new_cnt = take ? scan_cnt : best_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < K; k++) type_q[k] <= '0;
            for (int c = 0; c < C; c++) vote_q[c] <= '0;
`ifdef KNN_TIE_NEAREST_EN
            for (int c = 0; c < C; c++) first_q[c] <= '0;
`endif
            idx_q         <= '0;
            c_q           <= '0;
            best_cls_q    <= '0;
            best_cnt_q    <= '0;
            class_out_q   <= '0;
            class_votes_q <= '0;
            no_vote_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.valid_sort) begin
                    for (int k = 0; k < K; k++) type_q[k] <= bus.type_array_sorted[k];
                    for (int c = 0; c < C; c++) vote_q[c] <= '0;
`ifdef KNN_TIE_NEAREST_EN
                    for (int c = 0; c < C; c++) first_q[c] <= '0;
`endif
                    idx_q <= '0;
                end
                S_COUNT: begin
                    if (in_range) begin
                        vote_q[cur_cls] <= vote_q[cur_cls] + 8'd1;
`ifdef KNN_TIE_NEAREST_EN
                        if (vote_q[cur_cls] == 8'd0) first_q[cur_cls] <= idx_q;
`endif
                    end
                    if (last_idx) begin
                        idx_q      <= '0;
                        c_q        <= '0;
                        best_cls_q <= '0;
                        best_cnt_q <= '0;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                S_SCAN: begin
                    best_cls_q <= new_cls;
                    best_cnt_q <= new_cnt;
                    if (last_c) begin
                        c_q           <= '0;
                        class_out_q   <= new_cls;
                        class_votes_q <= new_cnt;
                        no_vote_q     <= (new_cnt == 8'd0);
                    end else begin
                        c_q <= c_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.class_out   = B'(class_out_q);
    assign bus.class_votes = class_votes_q;
    assign bus.no_vote     = no_vote_q;
    assign bus.valid_class = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign state_o         = state_q;
endmodule

// File: doc/knn_vote.md
# knn_vote

Consumer stage on the output side of `distance_sort`. On the sorter's `valid_sort` pulse it captures the first K entries of the sorted type array, which are the K nearest neighbours. It then counts votes per class sequentially and reports the majority class with a one-cycle `valid_class` strobe. It is the reader that closes the KNN datapath after sorting.

## Interface
Parameters:
- `N`, 64, length of the sorted arrays from `distance_sort`.
- `B`, 32, word width of each array entry.
- `K`, 5, number of nearest neighbours voting; 1 ≤ K ≤ N, K ≤ 255.
- `C`, 8, number of classes; valid types are 0..C-1; C ≤ 256.

Ports:
- `clk`  input  1  clock, all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `valid_sort`  input  1  one-cycle strobe from `distance_sort`; sorted arrays are stable in that cycle.
- `type_array_sorted`  input  B × [0:N-1]  class labels, nearest first.
- `class_out`  output  B  winning class.
- `class_votes`  output  8  vote count of the winning class.
- `no_vote`  output  1  high with `valid_class` when no captured type was in range.
- `valid_class`  output  1  one-cycle result strobe.
- `busy`  output  1  high in every state except IDLE.

## Operation
States:
- IDLE
  - `valid_sort`=1: latch `type_array_sorted[0..K-1]` into local regs, clear all C vote counters and `idx`, go to COUNT.
  - Otherwise stay in IDLE.
- COUNT, one neighbour per cycle, `idx` 0..K-1
  - If `type[idx]` < C: increment `vote[type[idx]]`.
  - Otherwise ignore the entry (out of range, no vote).
  - After `idx`=K-1: clear `idx`, go to SCAN.
- SCAN, one class per cycle, `c` 0..C-1
  - Running best starts at class 0 with count 0.
  - Replace the best when `vote[c]` > best count (strict compare, so the lower class keeps a tie).
  - Tie handling beyond that is set by the Configuration macro.
  - After `c`=C-1: go to DONE.
- DONE
  - Drive `class_out` and `class_votes`.
  - Drive `no_vote` = (best count == 0).
  - Pulse `valid_class` for one cycle, then go to IDLE.

Rules:
- Vote counters are 8 bits wide; they cannot overflow because K ≤ 255.
- `class_out` is zero-extended to B bits.
- `class_out`, `class_votes` and `no_vote` hold their values until the next DONE or reset.
- `valid_sort` outside IDLE, including in DONE, is ignored; it is not queued.
- The input arrays are sampled only in the capture cycle, so later changes to them have no effect.

## Timing
- Reset values: `class_out`=0, `class_votes`=0, `no_vote`=0, `valid_class`=0, `busy`=0; state=IDLE; all counters 0.
- With `valid_sort` sampled high at edge t:
  - `busy`=1 from t+1 until `valid_class` is seen.
  - `valid_class`=1 during cycle t+K+C+1 only.
  - Latency is K+C+1 cycles: 14 at the defaults.
- `rst` high at any edge, including mid-COUNT or mid-SCAN: everything returns to reset values at that edge, and no `valid_class` is produced for the aborted job.
- `rst` and `valid_sort` high at the same edge: `rst` wins and the job is dropped.
- Back-to-back jobs: the earliest accepted next `valid_sort` is the edge after DONE, which is the edge where `busy` is low.

## Configuration
- `KNN_TIE_NEAREST_EN` defined:
  - During COUNT, record for each class the index of its first occurrence (`first[c]`).
  - In SCAN, on equal counts, replace the best when `first[c]` < `first[best]`.
  - Result: a tie goes to the class whose member is nearest.
- Not defined:
  - No `first[]` storage.
  - On equal counts the lowest class number wins.
- Latency is identical either way.

## Test plan
All scenarios use K=5, C=8; `valid_sort` is sampled at edge t.
1. Types 3,3,5,2,3 → `class_out`=3, `class_votes`=3, `no_vote`=0. `valid_class` high only at t+14; `busy` high t+1..t+14.
2. Types 5,2,2,5,1:
   - With `KNN_TIE_NEAREST_EN` → `class_out`=5, votes 2.
   - Without → `class_out`=2, votes 2.
3. Types 9,9,9,1,9 → `class_out`=1, votes 1. Types 9,9,9,9,9 → `class_out`=0, votes 0, `no_vote`=1.
4. Second `valid_sort` at t+3 with different types → ignored; exactly one `valid_class`, at t+14, carrying the first job's result.
5. `rst` at t+6 → all outputs 0 from t+6 and no `valid_class`. A new `valid_sort` at t+10 with types 1,1,1,4,4 → `class_out`=1, votes 3, `valid_class` at t+24.
